bus_target_8088: RTL and testbench

Bus-side responder for the 8088 multiplexed local bus: decodes one address window, latches the address on `ale`, services byte reads and writes against a synchronous byte-wide memory port, and drives `ad` only while a decoded read is in its data phase. It sits between the CPU wrapper's `a`/`ad`/strobe pins and a RAM, ROM or peripheral register file, and it is the target-side counterpart of the CPU bus controller. Word transfers arrive as two back-to-back byte cycles with separate `ale` pulses, and the block treats each one independently.

---
 rtl/bus_target_8088_pkg.sv | 21 ++
 rtl/bus_target_8088_if.sv | 15 +
 rtl/bus_target_8088_addr_latch.sv | 47 ++++
 rtl/bus_target_8088.sv | 140 ++++++++++++++
 tb/tb_bus_target_8088.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_target_8088_pkg.sv
// Shared types and helpers for the 8088 bus target: FSM encoding,
// wait-counter width and the address-window compare.
package bus8088_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_e;

  localparam int WAIT_W = 4;

  // True when a falls in the 2^bits-byte window starting at base (base aligned).
  function automatic logic in_window(input logic [19:0] a,
                                     input logic [19:0] base,
                                     input int          bits);
    return ((a ^ base) >> bits) == 20'h00000;
  endfunction

endpackage

// File: rtl/bus_target_8088_if.sv
// CPU-side strobes and address of the 8088 local bus; the multiplexed ad
// bus is a plain inout on the target so tristate resolution stays simple.
interface bus_target_8088_if;

  logic [19:0] a;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        iom;
  logic        ready;

  modport master (output a, ale, rd_n, wr_n, iom, input ready);
  modport slave  (input a, ale, rd_n, wr_n, iom, output ready);

endinterface

// File: rtl/bus_target_8088_addr_latch.sv
// Address phase of the bus target: captures the offset and window hit
// whenever ale is high, and exposes the live decode for the FSM.
module bus_addr_latch
  import bus8088_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter int          ADDR_BITS = 14,
  parameter bit          IS_IO     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [19:0]          a,
  input  logic                 ale,
  input  logic                 iom,
  output logic                 hit_d,
  output logic                 hit_q,
  output logic [ADDR_BITS-1:0] mem_addr
);

  logic [ADDR_BITS-1:0] mem_addr_d;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic                 hit_next;

  // BASE_ADDR is window-aligned, so the low-bit subtraction is the true offset.
  always_comb begin
    hit_d      = in_window(a, BASE_ADDR, ADDR_BITS) && (iom == IS_IO);
    hit_next   = hit_q;
    mem_addr_d = mem_addr_q;
    if (ale) begin
      hit_next   = hit_d;
      mem_addr_d = a[ADDR_BITS-1:0] - BASE_ADDR[ADDR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      hit_q      <= hit_next;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_addr = mem_addr_q;

endmodule

// File: rtl/bus_target_8088.sv
// 8088 local-bus target: one decoded window, byte reads/writes against a
// synchronous memory port, ad driven only during a decoded read data phase.
module bus_target_8088
  import bus8088_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          ADDR_BITS   = 14,
  parameter bit          IS_IO       = 1'b0,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_target_8088_if.slave     bus,
  inout  wire  [7:0]           ad,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  output logic                 bus_err
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              first_q, first_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        wdata_q, wdata_d;

  logic              hit_d;
  logic              hit_q;
  logic              addr_phase;
  logic              rd_req;
  logic              wr_req;
  logic              ad_oe;
  logic [7:0]        ad_out;

  bus_addr_latch #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_BITS (ADDR_BITS),
    .IS_IO     (IS_IO)
  ) u_addr_latch (
    .clk      (clk),
    .rst      (rst),
    .a        (bus.a),
    .ale      (bus.ale),
    .iom      (bus.iom),
    .hit_d    (hit_d),
    .hit_q    (hit_q),
    .mem_addr (mem_addr)
  );

  assign addr_phase = (state_q == ADDR) && hit_q && !bus.ale;
  assign rd_req     = addr_phase && !bus.rd_n &&  bus.wr_n;
  assign wr_req     = addr_phase &&  bus.rd_n && !bus.wr_n;

  assign mem_re     = rd_req;
  assign mem_we     = wr_req;
  assign bus_err    = addr_phase && !bus.rd_n && !bus.wr_n;
  assign mem_wdata  = wr_req ? ad : wdata_q;

  // Memory data arrives one cycle after mem_re, so the first data cycle
  // forwards it straight through and later cycles replay the captured byte.
  assign ad_oe      = (state_q == RD) && !bus.ale;
  assign ad_out     = first_q ? mem_rdata : rdata_q;
  assign ad         = ad_oe ? ad_out : 8'bzzzz_zzzz;
  assign bus.ready  = ready_q;

  // A new ale always wins and abandons whatever cycle was in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    first_d = 1'b0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    if (bus.ale) begin
      state_d = hit_d ? ADDR : IDLE;
      cnt_d   = '0;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (rd_req) begin
            state_d = RD;
            cnt_d   = WAIT_INIT;
            ready_d = (WAIT_INIT == '0);
            first_d = 1'b1;
          end else if (wr_req) begin
            state_d = WR;
            wdata_d = ad;
          end
        end
        RD: begin
          if (first_q) begin
            rdata_d = mem_rdata;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
          ready_d = (cnt_q <= WAIT_W'(1));
          if (bus.rd_n) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
          end
        end
        WR: begin
          if (bus.wr_n) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      first_q <= 1'b0;
      rdata_q <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      first_q <= first_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_bus_target_8088.sv
// Directed bench for bus_target_8088: a zero-wait and a three-wait instance
// share one bus stimulus; released ad reads as 8'hFF through the pull-ups.
module tb_bus_target_8088;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic [19:0] a_r;
  logic        ale_r, rd_r, wr_r, iom_r;
  logic        drv_en;
  logic [7:0]  drv_val;

  bus_target_8088_if bus0 ();
  bus_target_8088_if bus3 ();

  assign bus0.a = a_r;    assign bus3.a = a_r;
  assign bus0.ale = ale_r; assign bus3.ale = ale_r;
  assign bus0.rd_n = rd_r; assign bus3.rd_n = rd_r;
  assign bus0.wr_n = wr_r; assign bus3.wr_n = wr_r;
  assign bus0.iom = iom_r; assign bus3.iom = iom_r;

  tri1 [7:0] ad0;
  tri1 [7:0] ad3;
  assign ad0 = drv_en ? drv_val : 8'bzzzz_zzzz;
  assign ad3 = drv_en ? drv_val : 8'bzzzz_zzzz;

  logic [13:0] mem_addr0, mem_addr3;
  logic        mem_re0, mem_re3, mem_we0, mem_we3, bus_err0, bus_err3;
  logic [7:0]  mem_wdata0, mem_wdata3;
  logic [7:0]  rdata0 = 8'h00;
  logic [7:0]  rdata3 = 8'h00;

  bus_target_8088 #(
    .BASE_ADDR (20'hF0000), .ADDR_BITS (14), .IS_IO (1'b0), .WAIT_STATES (0)
  ) dut0 (
    .clk (clk), .rst (rst), .bus (bus0), .ad (ad0),
    .mem_addr (mem_addr0), .mem_re (mem_re0), .mem_rdata (rdata0),
    .mem_we (mem_we0), .mem_wdata (mem_wdata0), .bus_err (bus_err0)
  );

  bus_target_8088 #(
    .BASE_ADDR (20'hF0000), .ADDR_BITS (14), .IS_IO (1'b0), .WAIT_STATES (3)
  ) dut3 (
    .clk (clk), .rst (rst), .bus (bus3), .ad (ad3),
    .mem_addr (mem_addr3), .mem_re (mem_re3), .mem_rdata (rdata3),
    .mem_we (mem_we3), .mem_wdata (mem_wdata3), .bus_err (bus_err3)
  );

  logic [7:0]  mem [0:16383];
  logic [21:0] wlog0[$];
  logic [21:0] wlog3[$];

  always @(posedge clk) begin
    if (mem_re0) rdata0 <= mem[mem_addr0];
    if (mem_re3) rdata3 <= mem[mem_addr3];
    if (mem_we0) wlog0.push_back({mem_addr0, mem_wdata0});
    if (mem_we3) wlog3.push_back({mem_addr3, mem_wdata3});
  end

  typedef struct {
    logic [19:0] a;
    logic        ale, rd_n, wr_n, iom, drv;
    logic [7:0]  dv;
    logic [7:0]  e_ad;
    logic        e_re, e_we, e_err;
    logic        chk_addr;
    logic [13:0] e_addr;
    logic [7:0]  e_wdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t row(input logic [19:0] a, input logic ale, input logic rd_n,
                               input logic wr_n, input logic iom, input logic drv,
                               input logic [7:0] dv, input logic [7:0] e_ad,
                               input logic e_re, input logic e_we, input logic e_err,
                               input logic chk_addr, input logic [13:0] e_addr,
                               input logic [7:0] e_wdata);
    vec_t v;
    v.a = a; v.ale = ale; v.rd_n = rd_n; v.wr_n = wr_n; v.iom = iom;
    v.drv = drv; v.dv = dv; v.e_ad = e_ad; v.e_re = e_re; v.e_we = e_we;
    v.e_err = e_err; v.chk_addr = chk_addr; v.e_addr = e_addr; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic apply_stimulus(input logic [19:0] a, input logic ale, input logic rd_n,
                                input logic wr_n, input logic iom, input logic drv,
                                input logic [7:0] dv);
    @(negedge clk);
    a_r = a; ale_r = ale; rd_r = rd_n; wr_r = wr_n; iom_r = iom;
    drv_en = drv; drv_val = dv;
    #4;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0123] = 8'hA5;
    mem[14'h0124] = 8'h5A;
    mem[14'h3FFF] = 8'hC3;

    // Cycle-by-cycle vectors for the zero-wait instance.
    vecs.push_back(row(20'h00000, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0123, H,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0123, L,L,H,L, L,8'h00, 8'hFF, H,L,L, H,14'h0123,8'h00));
    vecs.push_back(row(20'hF0123, L,L,H,L, L,8'h00, 8'hA5, L,L,L, H,14'h0123,8'h00));
    vecs.push_back(row(20'hF0123, L,H,H,L, L,8'h00, 8'hA5, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'h00000, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0010, H,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0010, L,H,L,L, H,8'hEF, 8'hEF, L,H,L, H,14'h0010,8'hEF));
    vecs.push_back(row(20'hF0010, L,H,L,L, H,8'hEF, 8'hEF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0010, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0011, H,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0011, L,H,L,L, H,8'hBE, 8'hBE, L,H,L, H,14'h0011,8'hBE));
    vecs.push_back(row(20'hF0011, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hE0123, H,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hE0123, L,L,H,L, L,8'h00, 8'hFF, L,L,L, H,14'h0123,8'h00));
    vecs.push_back(row(20'hE0123, L,L,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hE0123, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0123, H,H,H,H, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0123, L,L,H,H, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0123, L,L,H,H, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0123, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0124, H,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0124, L,L,L,L, L,8'h00, 8'hFF, L,L,H, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0124, L,L,L,L, L,8'h00, 8'hFF, L,L,H, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0124, L,L,H,L, L,8'h00, 8'hFF, H,L,L, H,14'h0124,8'h00));
    vecs.push_back(row(20'hF0124, L,L,H,L, L,8'h00, 8'h5A, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF0124, L,H,H,L, L,8'h00, 8'h5A, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'h00000, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF3FFF, H,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF3FFF, L,L,H,L, L,8'h00, 8'hFF, H,L,L, H,14'h3FFF,8'h00));
    vecs.push_back(row(20'hF3FFF, L,L,H,L, L,8'h00, 8'hC3, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF4000, H,L,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'hF4000, L,L,H,L, L,8'h00, 8'hFF, L,L,L, H,14'h0000,8'h00));
    vecs.push_back(row(20'hF4000, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));
    vecs.push_back(row(20'h00000, L,H,H,L, L,8'h00, 8'hFF, L,L,L, L,14'h0000,8'h00));

    rst = 1'b1;
    a_r = 20'h00000; ale_r = 1'b0; rd_r = 1'b1; wr_r = 1'b1; iom_r = 1'b0;
    drv_en = 1'b0; drv_val = 8'h00;
    #5;
    check_output("reset ready0", 32'(bus0.ready), 32'h1);
    check_output("reset ready3", 32'(bus3.ready), 32'h1);
    check_output("reset ad0", 32'(ad0), 32'hFF);
    check_output("reset mem_re0", 32'(mem_re0), 32'h0);
    check_output("reset mem_we0", 32'(mem_we0), 32'h0);
    check_output("reset bus_err0", 32'(bus_err0), 32'h0);
    check_output("reset mem_addr0", 32'(mem_addr0), 32'h0);
    check_output("reset mem_wdata0", 32'(mem_wdata0), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].ale, vecs[i].rd_n, vecs[i].wr_n,
                     vecs[i].iom, vecs[i].drv, vecs[i].dv);
      check_output($sformatf("vec%0d ready", i), 32'(bus0.ready), 32'h1);
      check_output($sformatf("vec%0d ad", i), 32'(ad0), 32'(vecs[i].e_ad));
      check_output($sformatf("vec%0d mem_re", i), 32'(mem_re0), 32'(vecs[i].e_re));
      check_output($sformatf("vec%0d mem_we", i), 32'(mem_we0), 32'(vecs[i].e_we));
      check_output($sformatf("vec%0d bus_err", i), 32'(bus_err0), 32'(vecs[i].e_err));
      if (vecs[i].chk_addr)
        check_output($sformatf("vec%0d mem_addr", i), 32'(mem_addr0), 32'(vecs[i].e_addr));
      if (vecs[i].e_we)
        check_output($sformatf("vec%0d mem_wdata", i), 32'(mem_wdata0), 32'(vecs[i].e_wdata));
    end

    check_output("write count dut0", 32'(wlog0.size()), 32'd2);
    check_output("write count dut3", 32'(wlog3.size()), 32'd2);
    if (wlog0.size() >= 2) begin
      check_output("write0 low byte", 32'(wlog0[0]), 32'({14'h0010, 8'hEF}));
      check_output("write0 high byte", 32'(wlog0[1]), 32'({14'h0011, 8'hBE}));
    end

    // Three-wait read of 0xF0123, then the second byte re-latched mid read.
    apply_stimulus(20'hF0123, H, H, H, L, L, 8'h00);
    apply_stimulus(20'hF0123, L, L, H, L, L, 8'h00);
    check_output("ws mem_re", 32'(mem_re3), 32'h1);
    check_output("ws mem_addr", 32'(mem_addr3), 32'h0123);
    check_output("ws ready addr phase", 32'(bus3.ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(20'hF0123, L, L, H, L, L, 8'h00);
      check_output($sformatf("ws ready d%0d", i), 32'(bus3.ready), (i >= 3) ? 32'h1 : 32'h0);
      check_output($sformatf("ws ad d%0d", i), 32'(ad3), 32'hA5);
    end
    apply_stimulus(20'hF0124, H, L, H, L, L, 8'h00);
    check_output("ws2 ad released", 32'(ad3), 32'hFF);
    check_output("ws2 ready", 32'(bus3.ready), 32'h1);
    apply_stimulus(20'hF0124, L, L, H, L, L, 8'h00);
    check_output("ws2 mem_re", 32'(mem_re3), 32'h1);
    check_output("ws2 mem_addr", 32'(mem_addr3), 32'h0124);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(20'hF0124, L, L, H, L, L, 8'h00);
      check_output($sformatf("ws2 ready d%0d", i), 32'(bus3.ready), (i >= 3) ? 32'h1 : 32'h0);
      check_output($sformatf("ws2 ad d%0d", i), 32'(ad3), 32'h5A);
    end
    apply_stimulus(20'hF0124, L, H, H, L, L, 8'h00);
    apply_stimulus(20'h00000, L, H, H, L, L, 8'h00);
    check_output("ws2 ad idle", 32'(ad3), 32'hFF);

    // Reset landing in the middle of a read data phase.
    apply_stimulus(20'hF0123, H, H, H, L, L, 8'h00);
    apply_stimulus(20'hF0123, L, L, H, L, L, 8'h00);
    apply_stimulus(20'hF0123, L, L, H, L, L, 8'h00);
    check_output("pre-rst ad0", 32'(ad0), 32'hA5);
    check_output("pre-rst ad3", 32'(ad3), 32'hA5);
    check_output("pre-rst ready3", 32'(bus3.ready), 32'h0);
    #2 rst = 1'b1;
    #2;
    check_output("rst ad0 released", 32'(ad0), 32'hFF);
    check_output("rst ad3 released", 32'(ad3), 32'hFF);
    check_output("rst ready3", 32'(bus3.ready), 32'h1);
    check_output("rst mem_addr0", 32'(mem_addr0), 32'h0);
    apply_stimulus(20'h00000, L, H, H, L, L, 8'h00);
    rst = 1'b0;
    apply_stimulus(20'hF0124, H, H, H, L, L, 8'h00);
    apply_stimulus(20'hF0124, L, L, H, L, L, 8'h00);
    check_output("post-rst mem_re0", 32'(mem_re0), 32'h1);
    check_output("post-rst mem_addr0", 32'(mem_addr0), 32'h0124);
    apply_stimulus(20'hF0124, L, L, H, L, L, 8'h00);
    check_output("post-rst ad0", 32'(ad0), 32'h5A);
    check_output("post-rst ad3", 32'(ad3), 32'h5A);
    check_output("post-rst ready3", 32'(bus3.ready), 32'h0);
    apply_stimulus(20'hF0124, L, H, H, L, L, 8'h00);
    apply_stimulus(20'h00000, L, H, H, L, L, 8'h00);
    check_output("post-rst ad0 idle", 32'(ad0), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
